// File: rtl/pc_sel_ctrl_pkg.sv
// rtl/pc_sel_ctrl_pkg.sv - PC-source select and exception FSM encodings
package pc_sel_ctrl_pkg;

  localparam logic [2:0] PCSRC_PLUS4 = 3'd0;
  localparam logic [2:0] PCSRC_BT    = 3'd1;
  localparam logic [2:0] PCSRC_JT    = 3'd2;
  localparam logic [2:0] PCSRC_JR    = 3'd3;
  localparam logic [2:0] PCSRC_ILLOP = 3'd4;
  localparam logic [2:0] PCSRC_XADR  = 3'd5;

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_EXC = 1'b1;

  function automatic logic [31:0] align4(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// rtl/pc_redirect_arb.sv - combinational priority arbiter for fetch redirects
module pc_redirect_arb
  import pc_sel_ctrl_pkg::*;
#(
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic        stall,
  input  logic [0:0]  state,
  input  logic        irq,
  input  logic        illop,
  input  logic        eret,
  input  logic        jr_take,
  input  logic        j_take,
  input  logic        br_take,
  input  logic [31:0] pc,
  input  logic [31:0] epc,
  input  logic [31:0] jr_tgt,
  input  logic [31:0] j_tgt,
  input  logic [31:0] br_tgt,
  output logic [2:0]  pc_src_sel,
  output logic        flush_if,
  output logic        flush_id,
  output logic        exc_enter,
  output logic        exc_return,
  output logic [31:0] next_pc
);

  always_comb begin
    pc_src_sel = PCSRC_PLUS4;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    exc_enter  = 1'b0;
    exc_return = 1'b0;
    next_pc    = pc + 32'd4;
    // A stalled cycle takes nothing; the requester keeps its request asserted.
    if (stall) begin
      next_pc = pc;
    end else if (illop) begin
      pc_src_sel = PCSRC_ILLOP;
      flush_if   = 1'b1;
      flush_id   = 1'b1;
      exc_enter  = 1'b1;
      next_pc    = align4(ILLOP_VEC);
    end else if (irq && state == ST_RUN) begin
      pc_src_sel = PCSRC_XADR;
      flush_if   = 1'b1;
      flush_id   = 1'b1;
      exc_enter  = 1'b1;
      next_pc    = align4(XADR_VEC);
    end else if (eret && state == ST_EXC) begin
      pc_src_sel = PCSRC_JR;
      flush_if   = 1'b1;
      exc_return = 1'b1;
      next_pc    = align4(epc);
    end else if (jr_take) begin
      pc_src_sel = PCSRC_JR;
      flush_if   = 1'b1;
      next_pc    = align4(jr_tgt);
    end else if (j_take) begin
      pc_src_sel = PCSRC_JT;
      flush_if   = 1'b1;
      next_pc    = align4(j_tgt);
    end else if (br_take) begin
      pc_src_sel = PCSRC_BT;
      flush_if   = 1'b1;
      next_pc    = align4(br_tgt);
    end
  end

endmodule

// File: rtl/pc_sel_ctrl.sv
// rtl/pc_sel_ctrl.sv - fetch PC register, redirect select and exception FSM
// Optional IRQ_SYNC_EN: 2-flop synchronizer on irq before arbitration.
module pc_sel_ctrl
  import pc_sel_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        irq,
  input  logic        illop,
  input  logic [31:0] id_pc,
  input  logic        jr_take,
  input  logic [31:0] jr_tgt,
  input  logic        j_take,
  input  logic [31:0] j_tgt,
  input  logic        br_take,
  input  logic [31:0] br_tgt,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [2:0]  pc_src_sel,
  output logic        flush_if,
  output logic        flush_id,
  output logic        in_exc,
  output logic [31:0] epc
);

  logic [0:0]  state;
  logic        irq_eff;
  logic        exc_enter;
  logic        exc_return;
  logic [31:0] next_pc;

`ifdef IRQ_SYNC_EN
  logic [1:0] irq_sync;

  always_ff @(posedge clk) begin
    if (rst) irq_sync <= 2'b00;
    else     irq_sync <= {irq_sync[0], irq};
  end

  assign irq_eff = irq_sync[1];
`else
  assign irq_eff = irq;
`endif

  pc_redirect_arb #(
    .ILLOP_VEC(ILLOP_VEC),
    .XADR_VEC (XADR_VEC)
  ) u_arb (
    .stall     (stall),
    .state     (state),
    .irq       (irq_eff),
    .illop     (illop),
    .eret      (eret),
    .jr_take   (jr_take),
    .j_take    (j_take),
    .br_take   (br_take),
    .pc        (pc),
    .epc       (epc),
    .jr_tgt    (jr_tgt),
    .j_tgt     (j_tgt),
    .br_tgt    (br_tgt),
    .pc_src_sel(pc_src_sel),
    .flush_if  (flush_if),
    .flush_id  (flush_id),
    .exc_enter (exc_enter),
    .exc_return(exc_return),
    .next_pc   (next_pc)
  );

  // Traps resume after the faulting instruction; interrupts replay the ID instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      epc   <= 32'd0;
      state <= ST_RUN;
    end else if (!stall) begin
      pc <= next_pc;
      if (exc_enter) begin
        state <= ST_EXC;
        epc   <= (pc_src_sel == PCSRC_ILLOP) ? id_pc + 32'd4 : id_pc;
      end else if (exc_return) begin
        state <= ST_RUN;
      end
    end
  end

  assign in_exc = (state == ST_EXC);

endmodule

// File: tb/tb_pc_sel_ctrl.sv
// tb/tb_pc_sel_ctrl.sv - scoreboard bench for pc_sel_ctrl
module tb_pc_sel_ctrl;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [2:0]  sel;
    logic        fi;
    logic        fd;
    logic        ie;
    logic [31:0] epc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, irq, illop, eret;
  logic        jr_take, j_take, br_take;
  logic [31:0] id_pc, jr_tgt, j_tgt, br_tgt;
  logic [31:0] pc, epc;
  logic [2:0]  pc_src_sel;
  logic        flush_if, flush_id, in_exc;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec      = 0;

  always #5 clk = ~clk;

  pc_sel_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .irq(irq), .illop(illop),
    .id_pc(id_pc), .jr_take(jr_take), .jr_tgt(jr_tgt), .j_take(j_take),
    .j_tgt(j_tgt), .br_take(br_take), .br_tgt(br_tgt), .eret(eret),
    .pc(pc), .pc_src_sel(pc_src_sel), .flush_if(flush_if),
    .flush_id(flush_id), .in_exc(in_exc), .epc(epc)
  );

  task automatic cmp(input int idx, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL v%0d %s actual=%h required=%h", idx, name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        cmp(e.idx, "pc",         pc,                 e.pc);
        cmp(e.idx, "pc_src_sel", {29'd0, pc_src_sel}, {29'd0, e.sel});
        cmp(e.idx, "flush_if",   {31'd0, flush_if},  {31'd0, e.fi});
        cmp(e.idx, "flush_id",   {31'd0, flush_id},  {31'd0, e.fd});
        cmp(e.idx, "in_exc",     {31'd0, in_exc},    {31'd0, e.ie});
        cmp(e.idx, "epc",        epc,                e.epc);
      end
    end
  end

  task automatic step(input logic [31:0] e_pc, input logic [2:0] e_sel,
                      input logic e_fi, input logic e_fd, input logic e_ie,
                      input logic [31:0] e_epc);
    exp_t e;
    e.idx = vec; e.pc = e_pc; e.sel = e_sel; e.fi = e_fi;
    e.fd = e_fd; e.ie = e_ie; e.epc = e_epc;
    q.push_back(e);
    vec++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; irq = 0; illop = 0; eret = 0;
    jr_take = 0; j_take = 0; br_take = 0;
    id_pc = 0; jr_tgt = 0; j_tgt = 0; br_tgt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Reset state and free-running PLUS4
    step(32'h0,  3'd0, 0, 0, 0, 32'h0);
    step(32'h4,  3'd0, 0, 0, 0, 32'h0);
    step(32'h8,  3'd0, 0, 0, 0, 32'h0);
    step(32'hC,  3'd0, 0, 0, 0, 32'h0);

    // Taken branch blocked by stall, then taken
    br_take = 1; br_tgt = 32'h40; stall = 1;
    step(32'h10, 3'd0, 0, 0, 0, 32'h0);
    stall = 0;
    step(32'h10, 3'd1, 1, 0, 0, 32'h0);
    idle();
    step(32'h40, 3'd0, 0, 0, 0, 32'h0);

    // Jump with unaligned target
    j_take = 1; j_tgt = 32'h107;
    step(32'h44, 3'd2, 1, 0, 0, 32'h0);
    idle();

    // Illegal op trap and return
    illop = 1; id_pc = 32'h20;
    step(32'h104, 3'd4, 1, 1, 0, 32'h0);
    idle();
    step(32'h8000_0004, 3'd0, 0, 0, 1, 32'h24);
    eret = 1;
    step(32'h8000_0008, 3'd3, 1, 0, 1, 32'h24);
    idle();
    step(32'h24, 3'd0, 0, 0, 0, 32'h24);
    eret = 1;
    step(32'h28, 3'd0, 0, 0, 0, 32'h24);
    idle();

    // irq + illop together: illop wins, irq held pending through the handler
    irq = 1; illop = 1; id_pc = 32'h30;
    step(32'h2C, 3'd4, 1, 1, 0, 32'h24);
    illop = 0;
    step(32'h8000_0004, 3'd0, 0, 0, 1, 32'h34);
    step(32'h8000_0008, 3'd0, 0, 0, 1, 32'h34);
    eret = 1; id_pc = 32'h50;
    step(32'h8000_000C, 3'd3, 1, 0, 1, 32'h34);
    eret = 0; id_pc = 32'h60; br_take = 1; br_tgt = 32'h200;
    step(32'h34, 3'd5, 1, 1, 0, 32'h34);
    idle();
    step(32'h8000_0008, 3'd0, 0, 0, 1, 32'h60);

    // Reset while in EXC
    rst = 1;
    step(32'h8000_000C, 3'd0, 0, 0, 1, 32'h60);
    rst = 0;
    step(32'h0, 3'd0, 0, 0, 0, 32'h0);

    // Exception not taken while stalled
    stall = 1; illop = 1; id_pc = 32'h8;
    step(32'h4, 3'd0, 0, 0, 0, 32'h0);
    idle();

    // JR beats J and BR
    jr_take = 1; jr_tgt = 32'h300; j_take = 1; j_tgt = 32'h400;
    br_take = 1; br_tgt = 32'h500;
    step(32'h4, 3'd3, 1, 0, 0, 32'h0);
    idle();

    // PLUS4 wrap at top of address space
    j_take = 1; j_tgt = 32'hFFFF_FFFC;
    step(32'h300, 3'd2, 1, 0, 0, 32'h0);
    idle();
    step(32'hFFFF_FFFC, 3'd0, 0, 0, 0, 32'h0);
    step(32'h0, 3'd0, 0, 0, 0, 32'h0);

    // irq rising edge latency
    irq = 1; id_pc = 32'h70;
`ifdef IRQ_SYNC_EN
    step(32'h4, 3'd0, 0, 0, 0, 32'h0);
    step(32'h8, 3'd0, 0, 0, 0, 32'h0);
    step(32'hC, 3'd5, 1, 1, 0, 32'h0);
`else
    step(32'h4, 3'd5, 1, 1, 0, 32'h0);
`endif
    idle();
    step(32'h8000_0008, 3'd0, 0, 0, 1, 32'h70);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sel_ctrl.md
Name: pc_sel_ctrl

Overview:
- Owns the fetch PC register of the pipelined MIPS core and drives the 3-bit PC-source select consumed by the PC-source mux.
- Arbitrates the redirect requests:
  - sequential PC+4;
  - branch target (BT);
  - jump target (JT);
  - jump register (JR);
  - illegal-op trap (ILLOP);
  - external interrupt (XADR).
- Tracks exception entry/return with a small FSM, saves the EPC, and emits the IF/ID flush strobes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ILLOP_VEC, 32'h8000_0004, illegal-instruction handler address.
- XADR_VEC, 32'h8000_0008, interrupt handler address.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  hazard stall; hold PC and FSM
- irq  in  1  level interrupt request
- illop  in  1  ID stage flags an illegal opcode
- id_pc  in  32  PC of the instruction currently in ID
- jr_take  in  1  JR resolved in ID
- jr_tgt  in  32  register target
- j_take  in  1  J/JAL in ID
- j_tgt  in  32  jump target
- br_take  in  1  taken branch in ID
- br_tgt  in  32  branch target
- eret  in  1  return-from-exception in ID
- pc  out  32  current fetch PC
- pc_src_sel  out  3  select for the cycle's PC update (PCSRC_* encoding)
- flush_if  out  1  kill the instruction in IF
- flush_id  out  1  kill the instruction in ID
- in_exc  out  1  handler active; interrupts masked
- epc  out  32  saved return address

Behaviour:
- Reset values:
  - pc = RESET_PC
  - pc_src_sel = PCSRC_PLUS4
  - epc = 0
  - in_exc = 0
  - flush_if = 0, flush_id = 0
  - state = RUN
- All outputs are registered except pc_src_sel, flush_if and flush_id. These three are combinational from the current-cycle inputs and state; pc updates on the next clk edge.
- Request priority, highest first:
  1. illop (any state)
  2. irq (RUN only)
  3. eret (EXC only)
  4. jr_take
  5. j_take
  6. br_take
  7. PLUS4
- Effect of the winning request:
  - ILLOP: pc <= ILLOP_VEC; epc <= id_pc + 4; flush_if = flush_id = 1.
  - XADR: pc <= XADR_VEC; epc <= id_pc; flush_if = flush_id = 1. The ID instruction is re-executed after return.
  - Both ILLOP and XADR move the FSM to EXC and set in_exc = 1 next cycle.
  - eret: pc <= epc; sel = PCSRC_JR; flush_if = 1; state -> RUN; in_exc <= 0.
  - JR, JT, BT: pc <= respective target; flush_if = 1. There is no delay slot.
  - PLUS4: pc <= pc + 4. Addition is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- FSM states are RUN and EXC:
  - RUN -> EXC on illop or irq.
  - EXC -> RUN on eret.
  - illop in EXC (nested trap) re-enters EXC and overwrites epc.
  - irq is ignored in EXC and remains pending (level-sensitive).
- stall = 1:
  - pc, epc and state are held; flushes = 0; pc_src_sel = PCSRC_PLUS4.
  - Exception requests are NOT taken while stalled. They are evaluated on the first unstalled cycle, and the upstream stage keeps them asserted.
- Simultaneous illop and irq: illop wins; irq is taken after the handler returns.
- Simultaneous irq and br_take in RUN: irq wins; epc = id_pc, so the branch re-executes after return.
- rst has priority over every other input mid-operation; in_exc clears.
- Low 2 bits of every target are forced to 0 when loaded into pc.

Optional Feature:
- IRQ_SYNC_EN.
  - Defined: irq passes through a 2-flop synchronizer (reset to 0) before arbitration. This adds 2 cycles of latency and makes the block safe for asynchronous irq sources.
  - Undefined: irq is used directly and must already be synchronous to clk.

Decomposition:
- Shared package/include `ctrl_encode_def.v` holds:
  - PCSRC_PLUS4=3'd0, PCSRC_BT=3'd1, PCSRC_JT=3'd2, PCSRC_JR=3'd3, PCSRC_ILLOP=3'd4, PCSRC_XADR=3'd5;
  - FSM state encodings ST_RUN=1'b0, ST_EXC=1'b1.
- One sub-module, pc_redirect_arb: purely combinational priority arbiter producing pc_src_sel, flush_if, flush_id and the next-pc value. The top level keeps the registers and FSM.

Test Plan:
- Reset, then 4 free-running cycles -> pc: 0, 4, 8, 12; pc_src_sel = 0 every cycle; flushes 0.
- At pc=0x10, assert br_take with br_tgt=0x40 -> sel=1, flush_if=1, next pc=0x40; with stall=1 simultaneously, pc holds at 0x10.
- illop with id_pc=0x20 -> sel=4, flush_if=flush_id=1, pc=0x8000_0004, epc=0x24, in_exc=1. Then eret -> sel=3, pc=0x24, in_exc=0.
- irq and illop in the same cycle -> ILLOP taken. irq held through the handler is ignored until eret, then taken on the next RUN cycle: pc=0x8000_0008, epc = the then-current id_pc.
- jr_take, j_take and br_take all asserted -> sel=3 and pc=jr_tgt. PLUS4 from pc=0xFFFF_FFFC -> pc=0.
- With IRQ_SYNC_EN defined, irq rising at cycle n -> redirect to XADR_VEC at edge n+3, not n+1. rst asserted while in EXC -> pc=RESET_PC and in_exc=0 next cycle.
